// File: rtl/uart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_frame_ctrl
// Description : Frame sequencer placed between an 8N1 UART receiver and the
//               command decoder. Parses HEADER, LEN, LEN payload bytes and an
//               XOR checksum. Enforces an inter-byte timeout. Buffers the
//               payload and releases only good frames over a valid/ready
//               stream.
// Ports       : clk50M    - system clock (50 MHz)
//               rst       - synchronous reset, active-high
//               rxd_data  - received byte, stable when rxd_flag rises
//               rxd_flag  - receiver status (0 receiving, 1 idle/done)
//               out_data  - payload byte
//               out_valid - out_data valid
//               out_ready - downstream accepts byte
//               out_last  - final payload byte of the frame
//               frame_ok  - one-cycle pulse, good frame accepted
//               frame_err - one-cycle pulse, frame discarded
//               err_code  - 0 overrun, 1 bad length, 2 checksum, 3 timeout
//               busy      - controller not idle
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_frame_ctrl #(
    parameter logic [7:0] HEADER      = 8'hA5,
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 104160
) (
    input  logic       clk50M,
    input  logic       rst,
    input  logic [7:0] rxd_data,
    input  logic       rxd_flag,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int              c_LW      = $clog2(MAX_LEN + 1);
    localparam int              c_IW      = $clog2(MAX_LEN);
    localparam logic [c_LW-1:0] c_ONE     = c_LW'(1);
    localparam logic [7:0]      c_MAX     = 8'(MAX_LEN);
    // The counter already reads 1 in the cycle after a strobe, so comparing
    // against TIMEOUT_CYC-2 makes it reach TIMEOUT_CYC-1 on the error edge.
    localparam logic [19:0]     c_TO_LAST = 20'(TIMEOUT_CYC - 2);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_LEN     = 3'd1;
    localparam logic [2:0] c_ST_PAYLOAD = 3'd2;
    localparam logic [2:0] c_ST_CHK     = 3'd3;
    localparam logic [2:0] c_ST_DRAIN   = 3'd4;

    localparam logic [1:0] c_ERR_OVERRUN = 2'd0;
    localparam logic [1:0] c_ERR_LEN     = 2'd1;
    localparam logic [1:0] c_ERR_CHK     = 2'd2;
    localparam logic [1:0] c_ERR_TIMEOUT = 2'd3;

    logic [2:0]      r_state;
    logic [2:0]      w_state_next;
    logic            r_flag_d;
    logic [c_LW-1:0] r_len;
    logic [c_LW-1:0] r_idx;
    logic [7:0]      r_chk;
    logic [19:0]     r_to_cnt;
    logic [7:0]      r_buf [0:MAX_LEN-1];

    logic            w_rx_stb;
    logic            w_counting;
    logic            w_timeout;
    logic            w_ok;
    logic            w_err;
    logic [1:0]      w_code;
    logic            w_xfer;

    assign w_rx_stb   = rxd_flag & ~r_flag_d;
    assign w_counting = (r_state == c_ST_LEN) || (r_state == c_ST_PAYLOAD) ||
                        (r_state == c_ST_CHK);
    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign w_timeout  = w_counting & ~w_rx_stb & (r_to_cnt == c_TO_LAST);

    assign out_valid = (r_state == c_ST_DRAIN);
    assign out_last  = out_valid && (r_idx == (r_len - c_ONE));
    assign out_data  = out_valid ? r_buf[r_idx[c_IW-1:0]] : 8'h00;
    assign busy      = (r_state != c_ST_IDLE);

    always_comb begin
        w_state_next = r_state;
        w_ok         = 1'b0;
        w_err        = 1'b0;
        w_code       = c_ERR_OVERRUN;
        w_xfer       = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_rx_stb && (rxd_data == HEADER)) begin
                    w_state_next = c_ST_LEN;
                end
            end
            c_ST_LEN: begin
                if (w_rx_stb) begin
                    if ((rxd_data == 8'h00) || (rxd_data > c_MAX)) begin
                        w_err        = 1'b1;
                        w_code       = c_ERR_LEN;
                        w_state_next = c_ST_IDLE;
                    end else begin
                        w_state_next = c_ST_PAYLOAD;
                    end
                end else if (w_timeout) begin
                    w_err        = 1'b1;
                    w_code       = c_ERR_TIMEOUT;
                    w_state_next = c_ST_IDLE;
                end
            end
            c_ST_PAYLOAD: begin
                if (w_rx_stb) begin
                    if ((r_idx + c_ONE) == r_len) begin
                        w_state_next = c_ST_CHK;
                    end
                end else if (w_timeout) begin
                    w_err        = 1'b1;
                    w_code       = c_ERR_TIMEOUT;
                    w_state_next = c_ST_IDLE;
                end
            end
            c_ST_CHK: begin
                if (w_rx_stb) begin
                    if (rxd_data != r_chk) begin
                        w_err        = 1'b1;
                        w_code       = c_ERR_CHK;
                        w_state_next = c_ST_IDLE;
                    end else begin
                        w_ok         = 1'b1;
                        w_state_next = c_ST_DRAIN;
                    end
                end else if (w_timeout) begin
                    w_err        = 1'b1;
                    w_code       = c_ERR_TIMEOUT;
                    w_state_next = c_ST_IDLE;
                end
            end
            c_ST_DRAIN: begin
                w_xfer = out_ready;
                // A byte arriving mid-drain is reported and dropped; the
                // drain itself carries on untouched.
                if (w_rx_stb) begin
                    w_err  = 1'b1;
                    w_code = c_ERR_OVERRUN;
                end
                if (out_ready && out_last) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk50M) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_flag_d  <= 1'b1;
            r_len     <= '0;
            r_idx     <= '0;
            r_chk     <= 8'h00;
            r_to_cnt  <= 20'd0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            r_state   <= w_state_next;
            r_flag_d  <= rxd_flag;
            frame_ok  <= w_ok;
            frame_err <= w_err;
            if (w_err) begin
                err_code <= w_code;
            end

            if (w_rx_stb) begin
                r_to_cnt <= 20'd1;
            end else if (w_counting) begin
                r_to_cnt <= r_to_cnt + 20'd1;
            end else begin
                r_to_cnt <= 20'd0;
            end

            if (w_rx_stb && (r_state == c_ST_LEN)) begin
                r_len <= rxd_data[c_LW-1:0];
                r_chk <= rxd_data;
                r_idx <= '0;
            end else if (w_rx_stb && (r_state == c_ST_PAYLOAD)) begin
                r_chk <= r_chk ^ rxd_data;
                r_idx <= r_idx + c_ONE;
            end else if (w_ok) begin
                r_idx <= '0;
            end else if (w_xfer && !out_last) begin
                r_idx <= r_idx + c_ONE;
            end
        end
    end

    // Payload storage carries no reset; contents only matter once written.
    always_ff @(posedge clk50M) begin
        if (w_rx_stb && (r_state == c_ST_PAYLOAD)) begin
            r_buf[r_idx[c_IW-1:0]] <= rxd_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_frame_ctrl
// Description : Self-checking bench for uart_rx_frame_ctrl. A protocol-level
//               reference model predicts frame events and payload transfers
//               into queues; a monitor compares them against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_frame_ctrl;

    localparam logic [7:0] c_HDR  = 8'hA5;
    localparam int         c_MAXL = 16;
    localparam int         c_TO   = 300;

    logic       clk50M = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rxd_data = 8'h00;
    logic       rxd_flag = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;

    uart_rx_frame_ctrl #(
        .HEADER      (c_HDR),
        .MAX_LEN     (c_MAXL),
        .TIMEOUT_CYC (c_TO)
    ) u_dut (
        .clk50M    (clk50M),
        .rst       (rst),
        .rxd_data  (rxd_data),
        .rxd_flag  (rxd_flag),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code),
        .busy      (busy)
    );

    always #10 clk50M = ~clk50M;

    int cyc = 0;
    always @(posedge clk50M) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int kind;   // 0 frame_ok, 1 frame_err
        int code;
        int at;
    } evt_t;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } dat_t;

    evt_t q_evt[$];
    dat_t q_data[$];

    bit         m_active = 0;
    int         m_len = -1;
    logic [7:0] m_pl[$];
    int         last_stb = 0;
    bit         rdy_rand = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_evt(input int kind, input int code, input int at);
        evt_t e;
        e.kind = kind;
        e.code = code;
        e.at   = at;
        q_evt.push_back(e);
    endtask

    // Protocol-level reference: frame boundaries, length/checksum rules and
    // overrun are decided from the byte stream alone.
    task automatic model_byte(input logic [7:0] b, input int s);
        logic [7:0] x;
        dat_t       dd;
        if (q_data.size() != 0) begin
            push_evt(1, 0, s + 1);
            return;
        end
        if (!m_active) begin
            if (b == c_HDR) begin
                m_active = 1;
                m_len    = -1;
                m_pl.delete();
            end
            return;
        end
        if (m_len < 0) begin
            if (b == 8'h00 || int'(b) > c_MAXL) begin
                push_evt(1, 1, s + 1);
                m_active = 0;
            end else begin
                m_len = int'(b);
            end
            return;
        end
        if (m_pl.size() < m_len) begin
            m_pl.push_back(b);
            return;
        end
        x = 8'(m_len);
        foreach (m_pl[i]) x = x ^ m_pl[i];
        if (b != x) begin
            push_evt(1, 2, s + 1);
        end else begin
            push_evt(0, 0, s + 1);
            foreach (m_pl[i]) begin
                dd.d = m_pl[i];
                dd.l = (i == m_len - 1);
                q_data.push_back(dd);
            end
        end
        m_active = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int low);
        @(posedge clk50M); #1;
        rxd_flag = 1'b0;
        rxd_data = b;
        repeat (low) begin
            @(posedge clk50M); #1;
        end
        rxd_flag = 1'b1;
        last_stb = cyc;
        model_byte(b, cyc);
    endtask

    task automatic send_bytes(input logic [7:0] bs[$]);
        foreach (bs[i]) send_byte(bs[i], 2);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((q_evt.size() != 0 || q_data.size() != 0) && n < limit) begin
            @(posedge clk50M); #1;
            n++;
        end
        chk("queues_drained", (q_evt.size() == 0 && q_data.size() == 0), 1);
        repeat (3) begin
            @(posedge clk50M); #1;
        end
    endtask

    // Monitor: pops and compares whenever the DUT presents an output.
    logic       p_stall = 0;
    logic [7:0] p_data = 8'h00;
    logic       p_last = 0;
    logic       p_xfer_nl = 0;
    logic       p_xfer_l = 0;

    always @(negedge clk50M) begin
        evt_t e;
        dat_t d;
        if (rst) begin
            p_stall   = 0;
            p_xfer_nl = 0;
            p_xfer_l  = 0;
        end else begin
            if (frame_ok && frame_err) chk("ok_err_exclusive", 1, 0);
            if (frame_ok || frame_err) begin
                if (q_evt.size() == 0) begin
                    chk("unexpected_event", {frame_ok, frame_err}, 0);
                end else begin
                    e = q_evt.pop_front();
                    chk("event_kind", frame_err, e.kind[0]);
                    if (frame_err) chk("err_code", err_code, e.code);
                    chk("event_cycle", cyc, e.at);
                end
            end
            if (frame_ok) chk("ok_with_first_valid", out_valid, 1);
            if (p_stall) begin
                chk("stall_valid_held", out_valid, 1);
                chk("stall_data_held", out_data, p_data);
                chk("stall_last_held", out_last, p_last);
            end
            if (p_xfer_nl) chk("back_to_back_valid", out_valid, 1);
            if (p_xfer_l) chk("busy_after_last", {busy, out_valid}, 0);
            if (out_valid && out_ready) begin
                if (q_data.size() == 0) begin
                    chk("unexpected_transfer", out_data, 0);
                end else begin
                    d = q_data.pop_front();
                    chk("out_data", out_data, d.d);
                    chk("out_last", out_last, d.l);
                end
            end else if (out_valid) begin
                chk("spurious_valid", (q_data.size() != 0), 1);
            end
            p_stall   = out_valid && !out_ready;
            p_data    = out_data;
            p_last    = out_last;
            p_xfer_nl = out_valid && out_ready && !out_last;
            p_xfer_l  = out_valid && out_ready && out_last;
        end
    end

    initial begin
        forever begin
            @(posedge clk50M); #1;
            if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #(20 * 80000);
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] fr[$];
        logic [7:0] x;
        int         kind;
        int         len;

        // Reset values, with rxd_flag rising exactly at reset exit.
        rxd_data = c_HDR;
        repeat (3) @(posedge clk50M);
        #1;
        chk("rst_frame_ok", frame_ok, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        rst      = 1'b0;
        rxd_flag = 1'b1;
        repeat (3) begin
            @(posedge clk50M); #1;
        end
        chk("no_strobe_at_reset_exit", busy, 0);

        // Good frame, downstream always ready.
        out_ready = 1'b1;
        send_bytes('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03});
        wait_idle(200);

        // Same frame with backpressure: stalled, then toggling.
        out_ready = 1'b0;
        send_bytes('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03});
        repeat (5) begin
            @(posedge clk50M); #1;
        end
        for (int i = 0; i < 12; i++) begin
            out_ready = ~i[0];
            @(posedge clk50M); #1;
        end
        out_ready = 1'b1;
        wait_idle(200);

        // Bad checksum, then bad lengths (zero and above maximum).
        send_bytes('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04});
        wait_idle(200);
        send_bytes('{8'hA5, 8'h00});
        wait_idle(200);
        chk("idle_after_len0", busy, 0);
        send_bytes('{8'hA5, 8'h11});
        wait_idle(200);
        chk("idle_after_len17", busy, 0);

        // Noise then a frame abandoned after one payload byte.
        send_bytes('{8'h00, 8'hFF, 8'hA5, 8'h02, 8'h11});
        push_evt(1, 3, last_stb + c_TO - 1);
        m_active = 0;
        repeat (c_TO + 5) begin
            @(posedge clk50M); #1;
        end
        wait_idle(200);

        // A byte landing on the would-be expiry cycle keeps the frame alive.
        send_byte(8'hA5, 2);
        send_byte(8'h01, c_TO - 3);
        send_byte(8'h5A, 2);
        send_byte(8'h5B, 2);
        wait_idle(200);

        // Overrun: a header strobed during a stalled drain is dropped.
        out_ready = 1'b0;
        send_bytes('{8'hA5, 8'h01, 8'h42, 8'h43});
        send_byte(8'hA5, 3);
        repeat (3) begin
            @(posedge clk50M); #1;
        end
        out_ready = 1'b1;
        wait_idle(200);
        chk("idle_after_overrun", busy, 0);

        // Reset in the middle of a payload.
        send_bytes('{8'hA5, 8'h04, 8'h11});
        @(posedge clk50M); #1;
        rst = 1'b1;
        @(posedge clk50M); #1;
        chk("midrst_outputs", {frame_ok, frame_err, err_code, out_valid, out_data, out_last, busy}, 0);
        rst      = 1'b0;
        m_active = 0;
        send_bytes('{8'hA5, 8'h01, 8'h7E, 8'h7F});
        wait_idle(200);

        // Randomized frames with random backpressure.
        rdy_rand = 1;
        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 5));
            if (kind <= 3) begin
                len = int'($urandom_range(1, c_MAXL));
                fr.delete();
                fr.push_back(c_HDR);
                fr.push_back(8'(len));
                x = 8'(len);
                for (int i = 0; i < len; i++) begin
                    fr.push_back(8'($urandom));
                    x = x ^ fr[fr.size() - 1];
                end
                if (kind == 3) x = x ^ 8'(1 << $urandom_range(0, 7));
                fr.push_back(x);
                foreach (fr[i]) send_byte(fr[i], int'($urandom_range(1, 4)));
            end else if (kind == 4) begin
                send_byte(c_HDR, int'($urandom_range(1, 4)));
                if ($urandom_range(0, 1) == 0) send_byte(8'h00, 2);
                else send_byte(8'($urandom_range(c_MAXL + 1, 255)), 2);
            end else begin
                send_byte(8'($urandom_range(0, 8'hA4)), int'($urandom_range(1, 4)));
            end
        end
        if (m_active) begin
            push_evt(1, 3, last_stb + c_TO - 1);
            m_active = 0;
        end
        rdy_rand = 0;
        @(posedge clk50M); #1;
        out_ready = 1'b1;
        wait_idle(c_TO + 2000);
        chk("final_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
